// File: rtl/alu_pkg.sv
// Shared types for the arbitrated ALU: operation codes, arbiter FSM states and
// bit positions of the {N,Z,C,V} flag vector.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_XOR = 2'b10,
    ALU_ROT = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    LIBRE     = 2'd0,
    EJECUTAR  = 2'd1,
    RESPONDER = 2'd2
  } estado_t;

  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin pick: the first valid requester found searching
// upward from the pointer, modulo NREQ, as a one-hot grant plus its index.
module arbitro_rr #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]                       i_valido,
  input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] i_puntero,
  output logic [NREQ-1:0]                       o_concesion,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] o_indice
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic          w_hallado;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_concesion = '0;
    o_indice    = '0;
    w_hallado   = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'((int'(i_puntero) + k) % NREQ);
      if (!w_hallado && i_valido[w_idx]) begin
        w_hallado          = 1'b1;
        o_indice           = w_idx;
        o_concesion[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unidad_logico_aritmetica.sv
// Combinational ALU: add, subtract, xor and an 8-bit rotate-left of op1[7:0]
// by op2[2:0]. N/Z/C/V are only produced for add/sub; logic ops give zero flags.
module unidad_logico_aritmetica
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  alu_op_t      i_control,
  output logic [N-1:0] o_resultado,
  output logic [3:0]   o_flags
);

  logic [N-1:0] w_b;
  logic [N-1:0] w_suma;
  logic         w_cout;
  logic         w_arit;
  logic [15:0]  w_doble;

  always_comb begin
    w_arit = ~i_control[1];
    // Subtraction is a + ~b + 1, so C is the carry-out (1 = no borrow).
    w_b = (i_control == ALU_SUB) ? ~i_b : i_b;
    {w_cout, w_suma} = {1'b0, i_a} + {1'b0, w_b} + {{N{1'b0}}, (i_control == ALU_SUB)};
    w_doble = {i_a[7:0], i_a[7:0]} << i_b[2:0];

    case (i_control)
      ALU_ADD, ALU_SUB: o_resultado = w_suma;
      ALU_XOR:          o_resultado = i_a ^ i_b;
      default:          o_resultado = {{(N-8){1'b0}}, w_doble[15:8]};
    endcase

    o_flags     = '0;
    o_flags[FN] = w_arit & w_suma[N-1];
    o_flags[FZ] = w_arit & (w_suma == '0);
    o_flags[FC] = w_arit & w_cout;
    o_flags[FV] = w_arit & ~(i_control[0] ^ i_a[N-1] ^ i_b[N-1]) & (i_a[N-1] ^ w_suma[N-1]);
  end

endmodule

// File: rtl/arbitro_alu.sv
// Shares one ALU between NREQ requesters with round-robin arbitration and a
// single operation in flight (LIBRE -> EJECUTAR -> RESPONDER -> LIBRE).
module arbitro_alu
  import alu_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valido,
  output logic [NREQ-1:0]   req_listo,
  input  logic [NREQ*N-1:0] req_op1,
  input  logic [NREQ*N-1:0] req_op2,
  input  logic [NREQ*2-1:0] req_control,
  output logic [NREQ-1:0]   resp_valido,
  input  logic [NREQ-1:0]   resp_listo,
  output logic [N-1:0]      resp_resultado,
  output logic [3:0]        resp_flags,
  output logic              ocupado,
  output estado_t           o_estado
);

  localparam int            PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] ULTIMO = PW'(NREQ - 1);

  // Handshakes: a transfer happens on a rising edge where valido and listo are
  // both high; requesters hold valido and payload until then, and the arbiter
  // never withdraws a listo/valido it raised without a transfer (except reset).
  estado_t       r_estado;
  logic [PW-1:0] r_puntero;
  logic [PW-1:0] r_owner;
  logic [N-1:0]  r_op1;
  logic [N-1:0]  r_op2;
  alu_op_t       r_control;
  logic [N-1:0]  r_resultado;
  logic [3:0]    r_flags;
  logic [NREQ-1:0] r_resp_valido;

  logic [NREQ-1:0] w_concesion;
  logic [PW-1:0]   w_indice;
  logic [N-1:0]    w_alu_res;
  logic [3:0]      w_alu_flags;
  logic            w_acepta;

  arbitro_rr #(.NREQ(NREQ)) u_rr (
    .i_valido    (req_valido),
    .i_puntero   (r_puntero),
    .o_concesion (w_concesion),
    .o_indice    (w_indice)
  );

  unidad_logico_aritmetica #(.N(N)) u_alu (
    .i_a         (r_op1),
    .i_b         (r_op2),
    .i_control   (r_control),
    .o_resultado (w_alu_res),
    .o_flags     (w_alu_flags)
  );

  // Grant is suppressed while reset is asserted so nothing looks accepted.
  assign req_listo = (r_estado == LIBRE && rst_n) ? w_concesion : '0;
  assign w_acepta  = |(req_valido & req_listo);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado      <= LIBRE;
      r_puntero     <= '0;
      r_owner       <= '0;
      r_op1         <= '0;
      r_op2         <= '0;
      r_control     <= ALU_ADD;
      r_resultado   <= '0;
      r_flags       <= '0;
      r_resp_valido <= '0;
    end else begin
      case (r_estado)
        LIBRE: begin
          if (w_acepta) begin
            r_op1     <= req_op1[w_indice*N +: N];
            r_op2     <= req_op2[w_indice*N +: N];
            r_control <= alu_op_t'(req_control[w_indice*2 +: 2]);
            r_owner   <= w_indice;
            r_puntero <= (w_indice == ULTIMO) ? '0 : w_indice + 1'b1;
            r_estado  <= EJECUTAR;
          end
        end
        EJECUTAR: begin
          r_resultado   <= w_alu_res;
          r_flags       <= w_alu_flags;
          r_resp_valido <= {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
          r_estado      <= RESPONDER;
        end
        RESPONDER: begin
          // Result registers deliberately keep their value after the handshake.
          if (resp_listo[r_owner]) begin
            r_resp_valido <= '0;
            r_estado      <= LIBRE;
          end
        end
        default: r_estado <= LIBRE;
      endcase
    end
  end

  assign resp_valido    = r_resp_valido;
  assign resp_resultado = r_resultado;
  assign resp_flags     = r_flags;
  assign ocupado        = (r_estado != LIBRE);
  assign o_estado       = r_estado;

endmodule
